// File: rtl/mem_port_arbiter_if.sv
// Memory port arbiter bus bundle: instruction, data and memory channels.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_addr;
    logic            i_re;
    logic [3:0]      i_sel;
    logic [XLEN-1:0] i_rdata;
    logic            i_ack;
    logic            i_err;

    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_sel;
    logic            d_re;
    logic            d_we;
    logic [XLEN-1:0] d_rdata;
    logic            d_ack;
    logic            d_err;

    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [3:0]      m_sel;
    logic            m_re;
    logic            m_we;
    logic [XLEN-1:0] m_rdata;
    logic            m_ack;

    logic [1:0]      grant;

    modport slave (
        input  i_addr, i_re, i_sel,
        input  d_addr, d_wdata, d_sel, d_re, d_we,
        input  m_rdata, m_ack,
        output i_rdata, i_ack, i_err,
        output d_rdata, d_ack, d_err,
        output m_addr, m_wdata, m_sel, m_re, m_we,
        output grant
    );

    modport master (
        output i_addr, i_re, i_sel,
        output d_addr, d_wdata, d_sel, d_re, d_we,
        output m_rdata, m_ack,
        input  i_rdata, i_ack, i_err,
        input  d_rdata, d_ack, d_err,
        input  m_addr, m_wdata, m_sel, m_re, m_we,
        input  grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// with a per-grant watchdog that forces an error completion.
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          re_q, re_d;
    logic          we_q, we_d;

    logic req_i, req_d, expire, done;

    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        re_d        = re_q;
        we_d        = we_q;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_sel   = '0;
        bus.m_re    = 1'b0;
        bus.m_we    = 1'b0;
        bus.i_ack   = 1'b0;
        bus.i_err   = 1'b0;
        bus.d_ack   = 1'b0;
        bus.d_err   = 1'b0;
        bus.grant   = 2'b00;

        req_i  = bus.i_re;
        req_d  = bus.d_re | bus.d_we;
        expire = (TIMEOUT != 0) && (state_q != IDLE) &&
                 !bus.m_ack && (cnt_q == TLIM);
        done   = (state_q != IDLE) && (bus.m_ack || expire);

        unique case (state_q)
            IDLE: begin
                if (req_i && (!req_d || last_q)) begin
                    state_d = GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                bus.m_addr = bus.i_addr;
                bus.m_sel  = bus.i_sel;
                bus.m_re   = re_q;
                bus.grant  = 2'b01;
                bus.i_ack  = bus.m_ack;
                bus.i_err  = expire;
                if (done) begin
                    last_d = 1'b0;
                    if (req_d)      state_d = GNT_D;
                    else if (req_i) state_d = GNT_I;
                    else            state_d = IDLE;
                end
            end
            GNT_D: begin
                bus.m_addr  = bus.d_addr;
                bus.m_wdata = bus.d_wdata;
                bus.m_sel   = bus.d_sel;
                bus.m_re    = re_q;
                bus.m_we    = we_q;
                bus.grant   = 2'b10;
                bus.d_ack   = bus.m_ack;
                bus.d_err   = expire;
                if (done) begin
                    last_d = 1'b1;
                    if (req_i)      state_d = GNT_I;
                    else if (req_d) state_d = GNT_D;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are latched at grant entry so a dropped request is carried.
        if (state_q == IDLE || done) begin
            cnt_d = '0;
            re_d  = (state_d == GNT_I) || ((state_d == GNT_D) && bus.d_re);
            we_d  = (state_d == GNT_D) && bus.d_we;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            we_q    <= we_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected completions are queued as
// requests are driven and compared when the owner's ack/err fires.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(32)) bus();

    mem_port_arbiter #(
        .XLEN    (32),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        re;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] gnt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input logic re, input logic we, input logic err,
                        input logic [31:0] rdata);
        exp_t e;
        e.gnt = gnt; e.addr = addr; e.wdata = wdata; e.sel = sel;
        e.re = re; e.we = we; e.err = err; e.rdata = rdata;
        q.push_back(e);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_gnt"}, {30'd0, bus.grant}, 32'd0);
        chk({tag, "_strb"}, {28'd0, bus.m_re, bus.m_we, bus.i_ack, bus.d_ack},
            32'd0);
        chk({tag, "_addr"}, bus.m_addr, 32'd0);
        chk({tag, "_err"}, {30'd0, bus.i_err, bus.d_err}, 32'd0);
        tick();
    endtask

    task automatic hold_chk(input string tag, input logic [1:0] gnt);
        @(negedge clk);
        chk({tag, "_gnt"}, {30'd0, bus.grant}, {30'd0, gnt});
        chk({tag, "_done"}, {28'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err},
            32'd0);
        tick();
    endtask

    task automatic serve(input string tag);
        exp_t e;
        logic ia, da, ie, de;
        @(negedge clk);
        nvec++;
        if (q.size() == 0) begin
            nfail++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = q.pop_front();
            ia = (e.gnt == 2'b01) && !e.err;
            da = (e.gnt == 2'b10) && !e.err;
            ie = (e.gnt == 2'b01) && e.err;
            de = (e.gnt == 2'b10) && e.err;
            chk({tag, "_gnt"}, {30'd0, bus.grant}, {30'd0, e.gnt});
            chk({tag, "_addr"}, bus.m_addr, e.addr);
            chk({tag, "_wdata"}, bus.m_wdata, e.wdata);
            chk({tag, "_sel"}, {28'd0, bus.m_sel}, {28'd0, e.sel});
            chk({tag, "_rewe"}, {30'd0, bus.m_re, bus.m_we}, {30'd0, e.re, e.we});
            chk({tag, "_ack"}, {30'd0, bus.i_ack, bus.d_ack}, {30'd0, ia, da});
            chk({tag, "_errs"}, {30'd0, bus.i_err, bus.d_err}, {30'd0, ie, de});
            if (ia) chk({tag, "_irdata"}, bus.i_rdata, e.rdata);
            if (da) chk({tag, "_drdata"}, bus.d_rdata, e.rdata);
        end
        tick();
    endtask

    initial begin
        bus.i_addr = '0; bus.i_re = 1'b0; bus.i_sel = '0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_sel = '0;
        bus.d_re = 1'b0; bus.d_we = 1'b0;
        bus.m_rdata = '0; bus.m_ack = 1'b0;

        #3;
        chk("rst_gnt", {30'd0, bus.grant}, 32'd0);
        chk("rst_strb", {30'd0, bus.m_re, bus.m_we}, 32'd0);
        tick();
        reset = 1'b0;

        // Contention: instr wins first tie, then owners alternate.
        bus.i_re = 1'b1; bus.i_addr = 32'h200; bus.i_sel = 4'hF;
        bus.d_we = 1'b1; bus.d_addr = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF; bus.d_sel = 4'hF;
        idle_chk("ct_c0");
        push(2'b01, 32'h200, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h11);
        push(2'b10, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h22);
        push(2'b01, 32'h200, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h33);
        push(2'b10, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h44);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h11;
        serve("ct_i1");
        bus.m_rdata = 32'h22;
        serve("ct_d1");
        bus.m_rdata = 32'h33; bus.i_re = 1'b0;
        serve("ct_i2");
        bus.m_rdata = 32'h44; bus.d_we = 1'b0;
        serve("ct_d2");
        bus.m_ack = 1'b0;
        idle_chk("ct_end");

        // Single fetch with one wait cycle.
        bus.i_re = 1'b1; bus.i_addr = 32'h100; bus.i_sel = 4'hF;
        idle_chk("sf_c0");
        push(2'b01, 32'h100, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h13);
        hold_chk("sf_c1", 2'b01);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h13; bus.i_re = 1'b0;
        serve("sf_ack");
        bus.m_ack = 1'b0;
        idle_chk("sf_end");

        // Back-to-back loads from the data side, zero-wait.
        bus.d_re = 1'b1; bus.d_addr = 32'h3000; bus.d_sel = 4'h3;
        bus.d_wdata = 32'h0;
        idle_chk("bb_c0");
        for (int k = 0; k < 3; k++)
            push(2'b10, 32'h3000, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0,
                 32'hA000 + 32'(k));
        bus.m_ack = 1'b1; bus.m_rdata = 32'hA000;
        serve("bb_1");
        bus.m_rdata = 32'hA001;
        serve("bb_2");
        bus.m_rdata = 32'hA002; bus.d_re = 1'b0;
        serve("bb_3");
        bus.m_ack = 1'b0;
        idle_chk("bb_end");

        // Watchdog: instr never acked, data pending behind it.
        bus.i_re = 1'b1; bus.i_addr = 32'h400; bus.i_sel = 4'hF;
        bus.d_re = 1'b1; bus.d_addr = 32'h5000; bus.d_sel = 4'hC;
        idle_chk("wd_c0");
        push(2'b01, 32'h400, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0);
        push(2'b10, 32'h5000, 32'h0, 4'hC, 1'b1, 1'b0, 1'b0, 32'h77);
        hold_chk("wd_c1", 2'b01);
        hold_chk("wd_c2", 2'b01);
        hold_chk("wd_c3", 2'b01);
        bus.i_re = 1'b0;
        serve("wd_err");
        bus.m_ack = 1'b1; bus.m_rdata = 32'h77; bus.d_re = 1'b0;
        serve("wd_data");
        bus.m_ack = 1'b0;
        idle_chk("wd_end");

        // Ack arriving in the expiry cycle wins over the error.
        bus.i_re = 1'b1; bus.i_addr = 32'h600; bus.i_sel = 4'h1;
        idle_chk("ae_c0");
        push(2'b01, 32'h600, 32'h0, 4'h1, 1'b1, 1'b0, 1'b0, 32'h99);
        hold_chk("ae_c1", 2'b01);
        hold_chk("ae_c2", 2'b01);
        hold_chk("ae_c3", 2'b01);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h99; bus.i_re = 1'b0;
        serve("ae_ack");
        bus.m_ack = 1'b0;
        idle_chk("ae_end");

        // Async reset in the middle of a store.
        bus.d_we = 1'b1; bus.d_addr = 32'h7000; bus.d_wdata = 32'h55;
        bus.d_sel = 4'hF;
        idle_chk("ar_c0");
        chk("ar_gnt", {30'd0, bus.grant}, 32'd2);
        chk("ar_we", {31'd0, bus.m_we}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_gnt0", {30'd0, bus.grant}, 32'd0);
        chk("ar_strb0", {29'd0, bus.m_re, bus.m_we, bus.d_ack}, 32'd0);
        bus.i_re = 1'b1; bus.i_addr = 32'h800; bus.i_sel = 4'hF;
        tick();
        chk("ar_hold", {30'd0, bus.grant}, 32'd0);
        reset = 1'b0;
        idle_chk("ar_rel");
        push(2'b01, 32'h800, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'hBB);
        push(2'b10, 32'h7000, 32'h55, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hBB; bus.i_re = 1'b0;
        serve("ar_i");
        bus.m_rdata = 32'h0; bus.d_we = 1'b0;
        serve("ar_d");
        bus.m_ack = 1'b0;
        idle_chk("ar_end");

        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch master and the load/store data master. Each requester sees a private request/acknowledge channel. The arbiter grants one requester at a time with round-robin fairness and holds the grant until the memory acknowledges or a watchdog expires. It sits between the core front-end/LSU and the external memory bus.

## Interface
Parameters:
- XLEN, 32, address and data width
- TIMEOUT, 16, cycles without ack before a forced error completion; 0 disables the watchdog

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_addr  in  XLEN  instruction request address
- i_re  in  1  instruction read request; held until i_ack or i_err
- i_sel  in  4  instruction byte select
- i_rdata  out  XLEN  instruction read data; equals m_rdata
- i_ack  out  1  instruction transfer complete
- i_err  out  1  instruction request timed out
- d_addr  in  XLEN  data request address
- d_wdata  in  XLEN  store data
- d_sel  in  4  data byte select
- d_re, d_we  in  1 each  data read/write request; held until d_ack or d_err
- d_rdata  out  XLEN  load data; equals m_rdata
- d_ack  out  1  data transfer complete
- d_err  out  1  data request timed out
- m_addr, m_wdata  out  XLEN each  memory port address / write data
- m_sel  out  4  memory byte select
- m_re, m_we  out  1 each  memory read/write strobe
- m_rdata  in  XLEN  memory read data
- m_ack  in  1  memory completion; may arrive in the same cycle as the strobe
- grant  out  2  current owner: 00 none, 01 instr, 10 data

## Operation
- State machine: IDLE, GNT_I, GNT_D. Registered state; last-owner bit `last` (0 = instr, 1 = data).
- Request terms: reqI = i_re; reqD = d_re | d_we.
- IDLE: only reqI -> GNT_I; only reqD -> GNT_D; both -> grant the side not equal to `last`; none -> stay.
- GNT_x: drive m_addr/m_wdata/m_sel/m_re/m_we from requester x. Data m_wdata comes from d_wdata; for the instruction side m_wdata = 0 and m_we = 0. Route m_ack to x_ack only.
- Completion (m_ack, or watchdog expiry): set `last` = x.
  - Next state: other side requesting -> GNT_other.
  - Else x still requesting -> GNT_x (back-to-back).
  - Else IDLE.
  - The same-cycle request of the completing side counts as a new request.
- IDLE: all m_* strobes, m_addr, m_wdata and m_sel are 0; i_ack, d_ack, i_err and d_err are 0.
- Watchdog: an unsigned counter of width $clog2(TIMEOUT+1) clears on every grant entry and increments each GNT cycle without m_ack. When it reaches TIMEOUT-1 with no m_ack, pulse x_err for one cycle (x_ack stays 0) and complete as above. If m_ack and expiry coincide, m_ack wins: ack, no err.
- d_re and d_we together: forwarded unchanged. The memory defines the result; the arbiter does not check for this.
- i_rdata and d_rdata are always m_rdata. They are valid only in the owner's ack cycle.

## Timing
- Reset (async, immediate): state IDLE, `last` = 1 (instr wins the first tie), counter 0, grant 00, all outputs 0.
- Arbitration latency: request seen in IDLE at cycle 0 -> grant and m_* strobes at cycle 1. Earliest x_ack is cycle 1 (combinational m_ack).
- Back-to-back: the next owner's strobes appear in the cycle after the ack, with no IDLE bubble.
- Acks and errs are combinational from m_ack and the registered state/counter. They never assert for the non-owner.
- Reset asserted mid-transfer: strobes drop the same cycle; the pending transfer is abandoned with no ack or err.
- Requester rule: address, sel, wdata and strobes stay stable from request until completion. A dropped request while granted is still carried until completion.

## Test plan
- Single instr fetch: i_re=1 with i_addr=0x100, m_ack 1 cycle after m_re -> grant=01 at cycle 1, m_addr=0x100, i_ack at cycle 2, d_ack stays 0.
- Contention: i_re=1 continuously; d_we=1 with d_addr=0x2000, d_wdata=0xDEADBEEF from cycle 0; m_ack every granted cycle -> owners alternate I,D,I. The store appears on m_* with m_we=1, and the instr side is never starved.
- Back-to-back same side: only d_re held for 3 transfers with 0-wait ack -> grant stays 10, 3 consecutive d_ack pulses, no IDLE cycle.
- Watchdog: TIMEOUT=4, i_re granted, m_ack never asserted -> i_err pulses on the 4th GNT_I cycle, i_ack=0, and the pending data request is granted the next cycle.
- Ack on expiry cycle: m_ack in the same cycle the counter reaches TIMEOUT-1 -> ack=1, err=0.
- Async reset mid-transfer: reset asserted during GNT_D with m_we=1 -> m_we, m_re and grant read 0 before the next clk edge. After release, with both sides requesting, the instr side is granted first.
